// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default widths
// for the bit-serial adder.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ADD_WIDTH = 8;
    localparam int CNT_W     = $clog2(ADD_WIDTH);

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the serial adder reuses one instance every cycle.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: {cout, sum} = a + b + cin, LSB first, one bit per clock
// through a single full-adder cell, with a start/busy/done handshake.
module serial_adder_8bit
    import arith_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [WIDTH-1:0]       acc;
    logic                   carry;
    logic [BIT_CNT_W-1:0]   cnt;
    logic                   fa_sum;
    logic                   fa_carry;
    logic                   accept;
    logic                   last;

    full_adder u_fa (
        .x     (op_a[0]),
        .y     (op_b[0]),
        .z     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == BIT_CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            // DONE accepts a new request directly for back-to-back operation
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a  <= a;
                op_b  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == ST_SHIFT) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                acc   <= {fa_sum, acc[WIDTH-1:1]};
                carry <= fa_carry;
                cnt   <= cnt + 1'b1;
            end
            // Outputs only change on the final shift so partial sums stay hidden
            if (last) begin
                sum  <= {fa_sum, acc[WIDTH-1:1]};
                cout <= fa_carry;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Self-checking bench for serial_adder_8bit: directed scenarios plus random
// traffic, compared every cycle against a cycle-count/arithmetic model.
module tb_serial_adder_8bit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles of work left, pending result, held outputs
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic [W:0]   m_pend = '0;

    serial_adder_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) {m_cout, m_sum} = m_pend;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_left = W;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("model_busy", 32'(busy), 32'(m_left > 0));
        check_eq("model_done", 32'(done), 32'(m_done));
        check_eq("model_sum",  32'(sum),  32'(m_sum));
        check_eq("model_cout", 32'(cout), 32'(m_cout));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] exp_sum, input logic exp_cout);
        int bc;
        int g;
        a = x; b = y; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        g  = 0;
        while (done !== 1'b1 && g < 20) begin
            bc += int'(busy);
            tick();
            g++;
        end
        check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(W));
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int first_done;
        int n_done;
        logic [W-1:0] s_at_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_sum",  32'(sum),  32'd0);
        check_eq("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        do_op("basic",  8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        do_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start while busy must be ignored
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        first_done = 0; n_done = 0; s_at_done = '0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            if (i == 4) begin start = 1'b0; a = '0; b = '0; end
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) begin first_done = i; s_at_done = sum; end
            end
        end
        check_eq("busy_start_ndone", 32'(n_done), 32'd1);
        check_eq("busy_start_lat", 32'(first_done), 32'(W));
        check_eq("busy_start_sum", 32'(s_at_done), 32'h30);

        // Back-to-back with start held
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h80; b = 8'h80;
        for (int i = 1; i <= 2 * W + 1; i++) begin
            tick();
            check_eq("b2b_busy_vs_done", 32'(busy), 32'(!done));
            if (i == W) begin
                check_eq("b2b_done1", 32'(done), 32'd1);
                check_eq("b2b_sum1", 32'(sum), 32'h03);
                check_eq("b2b_cout1", 32'(cout), 32'd0);
            end
            if (i == 2 * W + 1) begin
                check_eq("b2b_done2", 32'(done), 32'd1);
                check_eq("b2b_sum2", 32'(sum), 32'h00);
                check_eq("b2b_cout2", 32'(cout), 32'd1);
            end
        end
        start = 1'b0;
        tick();

        // Reset during the 4th SHIFT cycle
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_sum", 32'(sum), 32'd0);
        check_eq("rst_mid_cout", 32'(cout), 32'd0);
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_done += int'(done);
        end
        check_eq("rst_mid_no_done", 32'(n_done), 32'd0);
        do_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Result hold
        do_op("hold_op", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("hold_sum", 32'(sum), 32'h41);
            check_eq("hold_done", 32'(done), 32'd0);
        end
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 20 && done !== 1'b1; g++) begin
            check_eq("hold_partial_sum", 32'(sum), 32'h41);
            tick();
        end
        check_eq("hold_new_done", 32'(done), 32'd1);
        check_eq("hold_new_sum", 32'(sum), 32'h02);

        // Random traffic, including occasional reset and start/rst collisions
        for (int i = 0; i < 400; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
